// File: rtl/downscale_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : downscale_sequencer_if
// Function : Control, issue-handshake and status bundle of the bilinear
//            downscaler control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface downscale_sequencer_if #(
  parameter int LANES   = 4,
  parameter int COORD_W = 10
);
  logic                 start_proc_pulse;
  logic [COORD_W-1:0]   out_w;
  logic [COORD_W-1:0]   out_h;
  logic                 step_mode;
  logic                 step_pulse;
  logic                 abort;
  logic                 issue_ready;
  logic                 issue_valid;
  logic [COORD_W-1:0]   issue_x;
  logic [COORD_W-1:0]   issue_y;
  logic [LANES-1:0]     lane_mask;
  logic                 busy;
  logic                 done;
  logic                 aborted;
  logic [2*COORD_W-1:0] groups_done;
  logic [31:0]          stall_cycles;

  modport master (
    input  start_proc_pulse, out_w, out_h, step_mode, step_pulse, abort, issue_ready,
    output issue_valid, issue_x, issue_y, lane_mask, busy, done, aborted,
           groups_done, stall_cycles
  );

  modport slave (
    output start_proc_pulse, out_w, out_h, step_mode, step_pulse, abort, issue_ready,
    input  issue_valid, issue_x, issue_y, lane_mask, busy, done, aborted,
           groups_done, stall_cycles
  );
endinterface
`default_nettype wire

// File: rtl/downscale_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : downscale_sequencer
// Function : Raster-order output-pixel group issuer for the parallel bilinear
//            downscaler, with free-run, single-step, abort and backpressure.
//            Define DSEQ_PERF_EN to build the stall_cycles counter.
// Revision : 1.0 - initial release
// ============================================================================
module downscale_sequencer #(
  parameter int LANES       = 4,
  parameter int COORD_W     = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  aclr,
  downscale_sequencer_if.master bus
);
  localparam int            XW        = COORD_W + 5;
  localparam int            GW        = 2 * COORD_W;
  localparam logic [XW-1:0] LANES_X   = XW'(LANES);
  localparam logic [GW-1:0] GROUP_ONE = GW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] primed_q;
  logic                   start_prev_q;
  logic                   start_edge_q;
  logic                   step_prev_q;
  logic                   credit_q;
  logic [COORD_W-1:0]     w_q, h_q, x_q, y_q;
  logic [LANES-1:0]       mask_q;
  logic                   busy_q, done_q, aborted_q;
  logic [GW-1:0]          groups_q;

  logic                   start_lvl;
  logic                   step_edge;
  logic                   issue_valid;
  logic                   xfer;
  logic                   row_more;
  logic                   last_row;
  logic                   credit_d;
  logic [GW-1:0]          groups_d;
  logic [XW-1:0]          x_adv;

  function automatic logic [LANES-1:0] mask_for(input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] w);
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      m[i] = (({5'b0, x} + XW'(i)) < {5'b0, w});
    end
    return m;
  endfunction

  assign start_lvl   = sync_q[SYNC_STAGES-1];
  assign step_edge   = bus.step_pulse & ~step_prev_q;
  assign issue_valid = (state_q == S_RUN) & (~bus.step_mode | credit_q);
  assign xfer        = issue_valid & bus.issue_ready;
  assign x_adv       = {5'b0, x_q} + LANES_X;
  assign row_more    = (x_adv < {5'b0, w_q});
  assign last_row    = (({1'b0, y_q} + (COORD_W+1)'(1)) == {1'b0, h_q});
  assign groups_d    = xfer ? (groups_q + GROUP_ONE) : groups_q;

  // A fresh edge wins over a consuming transfer; extra edges saturate.
  always_comb begin
    credit_d = credit_q;
    if (step_edge) begin
      credit_d = 1'b1;
    end else if (xfer && bus.step_mode) begin
      credit_d = 1'b0;
    end
  end

  // start_prev_q resets high and only tracks once the chain holds real samples,
  // so a start level held across reset must fall and rise again to launch a run.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      sync_q       <= '0;
      primed_q     <= '0;
      start_prev_q <= 1'b1;
      start_edge_q <= 1'b0;
      step_prev_q  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], bus.start_proc_pulse};
      primed_q     <= {primed_q[SYNC_STAGES-2:0], 1'b1};
      if (primed_q[SYNC_STAGES-1]) begin
        start_prev_q <= start_lvl;
      end
      start_edge_q <= start_lvl & ~start_prev_q;
      step_prev_q  <= bus.step_pulse;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q   <= S_IDLE;
      credit_q  <= 1'b0;
      w_q       <= '0;
      h_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      mask_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      groups_q  <= '0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      credit_q  <= credit_d;
      case (state_q)
        S_IDLE: begin
          if (start_edge_q) begin
            w_q      <= bus.out_w;
            h_q      <= bus.out_h;
            x_q      <= '0;
            y_q      <= '0;
            groups_q <= '0;
            credit_q <= 1'b0;
            mask_q   <= mask_for('0, bus.out_w);
            if ((bus.out_w == '0) || (bus.out_h == '0)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          groups_q <= groups_d;
          if (bus.abort) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
          end else if (xfer) begin
            if (row_more) begin
              x_q    <= x_adv[COORD_W-1:0];
              mask_q <= mask_for(x_adv[COORD_W-1:0], w_q);
            end else if (last_row) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              x_q    <= '0;
              y_q    <= y_q + COORD_W'(1);
              mask_q <= mask_for('0, w_q);
            end
          end
        end
        S_DONE: begin
          if (!start_lvl) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.issue_valid = issue_valid;
  assign bus.issue_x     = x_q;
  assign bus.issue_y     = y_q;
  assign bus.lane_mask   = mask_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;
  assign bus.groups_done = groups_q;

`ifdef DSEQ_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      stall_q <= '0;
    end else if ((state_q == S_IDLE) && start_edge_q) begin
      stall_q <= '0;
    end else if (issue_valid && !bus.issue_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_q;
`else
  assign bus.stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_downscale_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_downscale_sequencer
// Function : Directed and randomised frames checked against a raster-order
//            group list computed from the frame dimensions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_downscale_sequencer;
  localparam int LANES   = 4;
  localparam int COORD_W = 10;
  localparam int SYNC    = 2;

  typedef struct {
    int               x;
    int               y;
    logic [LANES-1:0] m;
  } grp_t;

  logic clk  = 1'b0;
  logic aclr = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  grp_t q[$];

  downscale_sequencer_if #(.LANES(LANES), .COORD_W(COORD_W)) bus ();

  downscale_sequencer #(
    .LANES(LANES), .COORD_W(COORD_W), .SYNC_STAGES(SYNC)
  ) dut (
    .clk (clk),
    .aclr(aclr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LANES-1:0] exp_mask(input int x, input int w);
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) m[i] = ((x + i) < w);
    return m;
  endfunction

  task automatic run_frame(input int w, input int h, input bit stepm, input int rdy_pct,
                           input int abort_after, input int stall_first,
                           input int step_pct, input bit restart);
    int total, xfers, stalls, exp_st;
    bit running, pend_done, pend_abort, finished, credit, sprev, abort_sent;
    bit xfer_now, exp_valid;
    q.delete();
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx += LANES) q.push_back('{xx, yy, exp_mask(xx, w)});
    total = q.size();
    xfers = 0; stalls = 0; running = 0; pend_done = 0; pend_abort = 0;
    finished = 0; credit = 0; sprev = 0; abort_sent = 0;
    bus.out_w = w[COORD_W-1:0];
    bus.out_h = h[COORD_W-1:0];
    bus.step_mode = stepm;
    bus.issue_ready = 1'b0;
    bus.abort = 1'b0;
    bus.step_pulse = 1'b0;
    bus.start_proc_pulse = 1'b1;
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == 4) bus.start_proc_pulse = 1'b0;
      if (restart && cyc == 8) bus.start_proc_pulse = 1'b1;
      if (restart && cyc == 12) bus.start_proc_pulse = 1'b0;
      // start edge is registered after the synchroniser: RUN/DONE is entered at edge SYNC+2
      if (cyc == SYNC + 1) begin
        if (total == 0) pend_done = 1;
        else running = 1;
      end
      bus.abort = running && (abort_after >= 0) && (xfers == abort_after) && !abort_sent;
      if (bus.abort) abort_sent = 1;
      if (cyc < SYNC + 1 + stall_first) bus.issue_ready = 1'b0;
      else bus.issue_ready = ($urandom_range(0, 99) < rdy_pct);
      if (bus.abort && abort_after < total - 1) bus.issue_ready = 1'b0;
      bus.step_pulse = stepm && running && ($urandom_range(0, 99) < step_pct);
      #1;
      if (pend_done || pend_abort) begin
        chk("done_pulse", bus.done, pend_done);
        chk("aborted_pulse", bus.aborted, pend_abort);
        chk("busy_end", bus.busy, 0);
        chk("valid_end", bus.issue_valid, 0);
        chk("groups_done", bus.groups_done, xfers);
        finished = 1;
      end else begin
        exp_valid = running && (!stepm || credit);
        chk("busy", bus.busy, running);
        chk("done_idle", bus.done, 0);
        chk("aborted_idle", bus.aborted, 0);
        chk("issue_valid", bus.issue_valid, exp_valid);
        if (exp_valid && bus.issue_valid && q.size() > 0) begin
          chk("issue_x", bus.issue_x, q[0].x);
          chk("issue_y", bus.issue_y, q[0].y);
          chk("lane_mask", bus.lane_mask, q[0].m);
        end
        xfer_now = exp_valid && bus.issue_ready;
        if (exp_valid && !bus.issue_ready) stalls++;
        if (xfer_now) begin
          void'(q.pop_front());
          xfers++;
        end
        if (bus.abort) begin
          pend_abort = 1;
          running = 0;
        end else if (xfer_now && q.size() == 0) begin
          pend_done = 1;
          running = 0;
        end
        if (bus.step_pulse && !sprev) credit = 1;
        else if (xfer_now && stepm) credit = 0;
      end
      sprev = bus.step_pulse;
    end
    chk("frame_finished", finished, 1);
    bus.start_proc_pulse = 1'b0;
    bus.abort = 1'b0;
    bus.step_pulse = 1'b0;
    bus.issue_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("done_after", bus.done, 0);
    chk("aborted_after", bus.aborted, 0);
    chk("busy_after", bus.busy, 0);
`ifdef DSEQ_PERF_EN
    exp_st = stalls;
`else
    exp_st = 0;
`endif
    chk("stall_cycles", bus.stall_cycles, exp_st);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int w, h, ab;
    bit sm;
    bus.start_proc_pulse = 1'b0;
    bus.out_w = '0;
    bus.out_h = '0;
    bus.step_mode = 1'b0;
    bus.step_pulse = 1'b0;
    bus.abort = 1'b0;
    bus.issue_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", bus.issue_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_groups", bus.groups_done, 0);
    chk("rst_mask", bus.lane_mask, 0);
    @(negedge clk);
    aclr = 1'b0;
    repeat (5) @(negedge clk);

    run_frame(8, 2, 0, 100, -1, 0, 0, 0);
    run_frame(6, 1, 0, 100, -1, 0, 0, 0);
    run_frame(0, 5, 0, 100, -1, 0, 0, 0);
    run_frame(7, 0, 0, 100, -1, 0, 0, 0);
    run_frame(8, 1, 1, 100, -1, 0, 30, 0);
    run_frame(8, 1, 1, 40, -1, 0, 60, 0);
    run_frame(8, 1, 0, 100, -1, 5, 0, 0);
    run_frame(16, 4, 0, 100, 3, 0, 0, 0);
    run_frame(16, 4, 0, 80, -1, 0, 0, 1);
    run_frame(8, 1, 0, 100, 1, 0, 0, 0);

    // asynchronous reset mid-run with start held high
    bus.out_w = 10'd16;
    bus.out_h = 10'd4;
    bus.step_mode = 1'b0;
    bus.issue_ready = 1'b1;
    bus.start_proc_pulse = 1'b1;
    repeat (8) @(negedge clk);
    aclr = 1'b1;
    #1;
    chk("arst_valid", bus.issue_valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_x", bus.issue_x, 0);
    chk("arst_y", bus.issue_y, 0);
    chk("arst_groups", bus.groups_done, 0);
    chk("arst_stall", bus.stall_cycles, 0);
    @(negedge clk);
    aclr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      chk("held_start_busy", bus.busy, 0);
      chk("held_start_done", bus.done, 0);
    end
    bus.start_proc_pulse = 1'b0;
    bus.issue_ready = 1'b0;
    repeat (5) @(negedge clk);
    run_frame(16, 4, 0, 100, -1, 0, 0, 0);

    for (int f = 0; f < 8; f++) begin
      w  = $urandom_range(1, 24);
      h  = $urandom_range(1, 4);
      sm = ($urandom_range(0, 1) == 1);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_frame(w, h, sm, $urandom_range(40, 100), ab, $urandom_range(0, 3),
                $urandom_range(20, 80), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/downscale_sequencer.md
Name: downscale_sequencer

Overview:
Parametrised control sequencer for the parallel bilinear downscaler. It replaces the fixed-count control FSM. It walks the output image in raster order and issues groups of up to LANES consecutive output pixel coordinates per handshake to the datapath. Supports free-run, single-step, abort and backpressure, and reports progress, busy and done to the JTAG/host control side.

Parameters:
LANES, 4, output pixels issued per group (power of two, 1..16)
COORD_W, 10, width of output image dimensions and coordinates
SYNC_STAGES, 2, flop stages synchronising start_proc_pulse (>=2)

Ports:
clk  in  1  system clock
aclr  in  1  asynchronous reset, active-high
start_proc_pulse  in  1  start request, asynchronous to clk
out_w  in  COORD_W  output image width; sampled on start
out_h  in  COORD_W  output image height; sampled on start
step_mode  in  1  1 = issue one group per step_pulse rising edge
step_pulse  in  1  step request, synchronous to clk
abort  in  1  synchronous abort while running
issue_ready  in  1  datapath accepts a group
issue_valid  out  1  group coordinates valid
issue_x  out  COORD_W  x of lane 0 of the group
issue_y  out  COORD_W  row of the group
lane_mask  out  LANES  bit i set when issue_x+i < width
busy  out  1  high in RUN
done  out  1  one-cycle pulse on normal completion
aborted  out  1  one-cycle pulse on abort
groups_done  out  2*COORD_W  groups transferred since the last start
stall_cycles  out  32  backpressure cycle count (see Optional Feature)

Behaviour:
- Reset (aclr=1, async) values: state IDLE, all sync flops 0, step credit 0. Outputs: issue_valid=0, issue_x=0, issue_y=0, lane_mask=0, busy=0, done=0, aborted=0, groups_done=0, stall_cycles=0. Reset mid-run aborts silently, with no done or aborted pulse.
- Start path: start_proc_pulse passes through SYNC_STAGES flops, then a rising-edge detect (sync vs previous). Only a rising edge in IDLE starts a run. Edges in RUN or DONE are ignored. busy rises SYNC_STAGES+1 edges after the first edge sampling start high.
- States and transitions:
  - IDLE: on start edge, latch W=out_w and H=out_h, clear x, y and groups_done, clear step credit. If W==0 or H==0, go to DONE and pulse done. Otherwise go to RUN.
  - RUN: a transfer occurs when issue_valid && issue_ready. On each transfer, groups_done increments.
    - If x+LANES < W: x += LANES.
    - Else, if y==H-1: go to DONE and pulse done in the next cycle, with busy=0 in the same cycle.
    - Otherwise: x=0, y+=1.
  - DONE: go to IDLE when the synchronised start level is 0. done is high only in the first DONE cycle.
- issue_valid in RUN: equals 1 when step_mode=0; equals the step credit when step_mode=1. issue_valid is 0 outside RUN.
- Step credit: a 1-bit credit, set by a rising edge of step_pulse and cleared by a transfer in step mode. If a new edge and a consuming transfer occur in the same cycle, the credit stays 1. Extra edges saturate (no queueing). step_mode may change at any time; the credit is kept but only used while step_mode=1.
- Stability: while issue_valid=1 and issue_ready=0, issue_x, issue_y and lane_mask hold constant. issue_valid does not drop until transfer or abort.
- lane_mask bit i = (x+i < W). Arithmetic uses COORD_W+5 bits so there is no wrap. Only the last group of a row can be partial.
- Abort: abort=1 in RUN moves to IDLE on the next edge. busy=0 and issue_valid=0 from that edge. aborted pulses 1 cycle. done is not asserted. groups_done is retained. abort is ignored outside RUN. If abort coincides with the final transfer, abort wins: the transfer counts, aborted pulses, done does not.

Optional Feature:
Macro DSEQ_PERF_EN.
- Defined: stall_cycles counts cycles in RUN with issue_valid=1 and issue_ready=0. It saturates at all-ones, clears on start and holds otherwise.
- Undefined: stall_cycles is tied to 0 and no counter logic is present.

Test Plan:
1. LANES=4, W=8, H=2, step_mode=0, ready=1 -> four groups (0,0) (4,0) (0,1) (4,1), all mask 1111. done pulses 1 cycle after the last transfer, busy falls with it, groups_done=4.
2. W=6, H=1 -> groups (0,0) mask 1111, then (4,0) mask 0011; groups_done=2. Also W=0 -> done with no issue_valid, busy never set.
3. step_mode=1, W=8, H=1 -> no issue_valid until step_pulse. One pulse gives exactly one group. Two pulse edges with ready=0 then ready=1 give only one group.
4. W=8, H=1, issue_ready low for 5 cycles on the first group -> coordinates and mask stable, one transfer after ready rises. With DSEQ_PERF_EN, stall_cycles=5; without it, stall_cycles=0.
5. W=16, H=4, abort after 3 transfers -> busy=0 and issue_valid=0 next cycle, aborted 1-cycle pulse, done stays 0, groups_done=3. A new start runs the full 16 groups.
6. aclr pulse mid-run -> all outputs at reset values immediately. start held high across reset gives no run until start falls and rises again. A second start edge during RUN is ignored.
